led_fade_driver: RTL and testbench

Output-side counterpart to the push-button front end. It consumes single-cycle per-channel toggle events and drives the board LEDs with a PWM brightness level. Each channel ramps linearly on or off instead of switching hard. The block sits between the debounced key-event logic and the LED pins, and it is the LED driver every key/LED test design in the codebase instantiates.

---
 rtl/led_fade_pkg.sv | 16 +
 rtl/led_fade_channel.sv | 85 ++++++++
 rtl/led_fade_driver.sv | 52 +++++
 tb/tb_led_fade_driver.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/led_fade_pkg.sv
// rtl/led_fade_pkg.sv - shared state encoding and level range for the LED fade driver
package led_fade_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_RISE = 2'd1,
    ST_ON   = 2'd2,
    ST_FALL = 2'd3
  } fade_state_t;

  // Full-brightness level for a given PWM resolution.
  function automatic int unsigned lmax_of(input int unsigned bits);
    return (32'd1 << bits) - 32'd1;
  endfunction

endpackage

// File: rtl/led_fade_channel.sv
// rtl/led_fade_channel.sv - one LED channel: fade FSM, level register, PWM compare, pin register
module led_fade_channel
  import led_fade_pkg::*;
#(
  parameter int PWM_BITS   = 8,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic                toggle,
  output logic                led_out,
  output logic                busy
);

  localparam logic [PWM_BITS-1:0] LMAX = PWM_BITS'(lmax_of(PWM_BITS));
  localparam logic                POL  = (ACTIVE_LOW != 0);

  fade_state_t         state_q, state_d;
  logic [PWM_BITS-1:0] level_q, level_d;
  logic                lit;
  logic                led_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_OFF;
      level_q <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
    end
  end

  // A toggle always wins over a tick in the same cycle, so reversal never also steps.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    unique case (state_q)
      ST_OFF: begin
        level_d = '0;
        if (toggle) state_d = ST_RISE;
      end
      ST_RISE: begin
        if (toggle) begin
          state_d = ST_FALL;
        end else if (tick) begin
          if (level_q != LMAX) level_d = level_q + 1'b1;
          if (level_q >= LMAX - 1'b1) state_d = ST_ON;
        end
      end
      ST_ON: begin
        level_d = LMAX;
        if (toggle) state_d = ST_FALL;
      end
      ST_FALL: begin
        if (toggle) begin
          state_d = ST_RISE;
        end else if (tick) begin
          if (level_q != '0) level_d = level_q - 1'b1;
          if (level_q <= PWM_BITS'(1)) state_d = ST_OFF;
        end
      end
      default: begin
        state_d = ST_OFF;
        level_d = '0;
      end
    endcase
  end

  // Full scale is special-cased so LMAX is lit every cycle rather than LMAX of 2^PWM_BITS.
  assign lit = (level_q == LMAX) || (level_q > pwm_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q <= POL;
    end else begin
      led_q <= lit ^ POL;
    end
  end

  assign led_out = led_q;
  assign busy    = (state_q == ST_RISE) || (state_q == ST_FALL);

endmodule

// File: rtl/led_fade_driver.sv
// rtl/led_fade_driver.sv - multi-channel LED fade driver: shared step prescaler and PWM counter
module led_fade_driver
  import led_fade_pkg::*;
#(
  parameter int N_CH       = 2,
  parameter int PWM_BITS   = 8,
  parameter int STEP_DIV   = 50_000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] toggle_in,
  output logic [N_CH-1:0] led_out,
  output logic [N_CH-1:0] busy
);

  localparam int              PRE_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(STEP_DIV - 1);

  logic [PRE_W-1:0]    pre_cnt;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                tick;

  assign tick = (pre_cnt == PRE_LAST);

  // Free-running: toggles never restart the prescaler, so ramp start jitters by up to one step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
      pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    led_fade_channel #(
      .PWM_BITS  (PWM_BITS),
      .ACTIVE_LOW(ACTIVE_LOW)
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .tick   (tick),
      .pwm_cnt(pwm_cnt),
      .toggle (toggle_in[i]),
      .led_out(led_out[i]),
      .busy   (busy[i])
    );
  end

endmodule

// File: tb/tb_led_fade_driver.sv
// tb/tb_led_fade_driver.sv - randomized self-checking bench for led_fade_driver
module tb_led_fade_driver;

  localparam int N_CH     = 2;
  localparam int PWM_BITS = 3;
  localparam int STEP_DIV = 4;
  localparam int LMAX     = 7;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] toggle_in;
  logic [1:0] led_out;
  logic [1:0] busy;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: each channel has a brightness, a target direction and a "still moving" flag.
  int         lvl [2];
  bit         up  [2];
  bit         mov [2];
  int         pcnt;
  int         pwm;
  logic [1:0] exp_led;

  always #5 clk = ~clk;

  led_fade_driver #(
    .N_CH      (N_CH),
    .PWM_BITS  (PWM_BITS),
    .STEP_DIV  (STEP_DIV),
    .ACTIVE_LOW(1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .toggle_in(toggle_in),
    .led_out  (led_out),
    .busy     (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < 2; c++) begin
      lvl[c] = 0;
      up[c]  = 1'b0;
      mov[c] = 1'b0;
    end
    pcnt    = 0;
    pwm     = 0;
    exp_led = 2'b11;
  endfunction

  function automatic logic [1:0] exp_busy();
    return {mov[1], mov[0]};
  endfunction

  function automatic void model_edge(input logic [1:0] tg);
    bit tk;
    if (!rst_n) begin
      model_reset();
      return;
    end
    tk = (pcnt == STEP_DIV - 1);
    for (int c = 0; c < 2; c++)
      exp_led[c] = !((lvl[c] == LMAX) || (lvl[c] > pwm));
    for (int c = 0; c < 2; c++) begin
      if (tg[c]) begin
        up[c]  = !up[c];
        mov[c] = 1'b1;
      end else if (tk && mov[c]) begin
        lvl[c] = up[c] ? ((lvl[c] < LMAX) ? lvl[c] + 1 : LMAX) : ((lvl[c] > 0) ? lvl[c] - 1 : 0);
        if (lvl[c] == (up[c] ? LMAX : 0)) mov[c] = 1'b0;
      end
    end
    pcnt = (pcnt + 1) % STEP_DIV;
    pwm  = (pwm + 1) % (LMAX + 1);
  endfunction

  task automatic step(input logic [1:0] tg);
    @(negedge clk);
    check("led_out", 32'(led_out), 32'(exp_led));
    check("busy", 32'(busy), 32'(exp_busy()));
    toggle_in = tg;
    @(posedge clk);
    model_edge(tg);
  endtask

  task automatic wait_level(input int c, input int val, input int limit);
    int n = 0;
    while (!(mov[c] && lvl[c] == val) && n < limit) begin
      step(2'b00);
      n++;
    end
    if (!(mov[c] && lvl[c] == val)) check("wait_level_timeout", 0, 1);
  endtask

  task automatic wait_settle(input int c, input int limit, output int n);
    n = 0;
    while (mov[c] && n < limit) begin
      step(2'b00);
      n++;
    end
    if (mov[c]) check("wait_settle_timeout", 0, 1);
  endtask

  initial begin
    int n;
    int lows;
    rst_n     = 1'b0;
    toggle_in = 2'b00;
    model_reset();

    // Reset state, then long idle after release
    for (int i = 0; i < 4; i++) step(2'b00);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 100; i++) step(2'b00);
    #1 check("idle_led", 32'(led_out), 32'h3);
    check("idle_busy", 32'(busy), 32'h0);

    // Full ramp on ch0
    step(2'b01);
    #1 check("ramp_busy_rise", 32'(busy), 32'h1);
    wait_settle(0, 40, n);
    check("ramp_within_31", 32'(n <= 31), 32'h1);
    for (int i = 0; i < 10; i++) begin
      step(2'b00);
      #1 check("ramp_on_led", 32'(led_out), 32'h2);
      check("ramp_on_busy", 32'(busy), 32'h0);
    end

    // Back to OFF, then reverse mid-rise at level 3
    step(2'b01);
    wait_settle(0, 40, n);
    step(2'b01);
    wait_level(0, 3, 40);
    step(2'b01);
    wait_settle(0, 40, n);
    check("rev_steps_cycles", 32'(n <= 13), 32'h1);
    for (int i = 0; i < 10; i++) begin
      step(2'b00);
      #1 check("rev_off_led", 32'(led_out), 32'h3);
    end

    // Toggle ch1 exactly on a tick cycle
    while (pcnt != STEP_DIV - 1) step(2'b00);
    step(2'b10);
    #1 check("prio_busy", 32'(busy[1]), 32'h1);
    check("prio_level", 32'(lvl[1]), 32'h0);
    wait_settle(1, 40, n);

    // Hold ch0 at level 4 by toggling on every tick; expect 4 of 8 cycles lit
    step(2'b01);
    wait_level(0, 4, 40);
    lows = 0;
    for (int i = 0; i < 26; i++) begin
      step({1'b0, pcnt == STEP_DIV - 1});
      if (i >= 10) begin
        #1 if (led_out[0] == 1'b0) lows++;
      end
    end
    check("duty_lows_16", 32'(lows), 32'd8);
    check("duty_level", 32'(lvl[0]), 32'd4);

    // Reset during FALL at level 5
    wait_settle(0, 40, n);
    if (!up[0]) begin
      step(2'b01);
      wait_settle(0, 40, n);
    end
    step(2'b01);
    wait_level(0, 5, 40);
    #2 rst_n = 1'b0;
    #1 check("rst_mid_led", 32'(led_out), 32'h3);
    check("rst_mid_busy", 32'(busy), 32'h0);
    model_reset();
    for (int i = 0; i < 3; i++) step(2'b00);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 20; i++) step(2'b00);

    // Random toggle traffic against the model
    for (int i = 0; i < 3000; i++)
      step({$urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
